// File: rtl/dsp_mac_pipe.sv
// Pipelined signed multiply-accumulate: input register, MSTAGES product registers,
// single-cycle accumulator with optional saturation, sticky overflow and pattern detect.
module dsp_mac_pipe #(
  parameter int              AW       = 18,
  parameter int              BW       = 18,
  parameter int              PW       = 48,
  parameter int              MSTAGES  = 2,
  parameter int              SATURATE = 1,
  parameter logic [PW-1:0]   PATTERN  = '0
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 IN_VALID,
  input  logic signed [AW-1:0] A,
  input  logic signed [BW-1:0] B,
  input  logic signed [PW-1:0] C,
  input  logic [1:0]           OPMODE,
  input  logic                 CLR_OVF,
  output logic signed [PW-1:0] P,
  output logic [PW-1:0]        PCOUT,
  output logic                 OUT_VALID,
  output logic                 OVERFLOW,
  output logic                 PATDET
);

  // Handshake: no back-pressure. Every cycle with IN_VALID=1 is accepted and
  // produces exactly one OUT_VALID pulse MSTAGES+2 cycles later; bubbles travel
  // with the data through the valid shift register.

  localparam int MW = AW + BW;
  localparam int EW = PW + 1;
  localparam logic [PW-1:0] SAT_MAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] SAT_MIN = {1'b1, {(PW-1){1'b0}}};

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ACC  = 2'b01;
  localparam logic [1:0] OP_ADDC = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  // Stage 0: operand capture
  logic signed [AW-1:0] a_q;
  logic signed [BW-1:0] b_q;
  logic signed [PW-1:0] c_q;
  logic [1:0]           op_q;
  logic [MSTAGES:0]     v_sr;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      op_q <= '0;
    end else if (IN_VALID) begin
      a_q  <= A;
      b_q  <= B;
      c_q  <= C;
      op_q <= OPMODE;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) v_sr <= '0;
    else       v_sr <= {v_sr[MSTAGES-1:0], IN_VALID};
  end

  // Full-precision product; operands widened first so the multiply is MW bits wide
  logic signed [MW-1:0] a_ext;
  logic signed [MW-1:0] b_ext;
  logic signed [MW-1:0] prod;

  assign a_ext = MW'(a_q);
  assign b_ext = MW'(b_q);
  assign prod  = a_ext * b_ext;

  // Multiplier pipeline; C and OPMODE ride alongside M
  logic signed [MW-1:0] m_q  [MSTAGES];
  logic signed [PW-1:0] c_d  [MSTAGES];
  logic [1:0]           op_d [MSTAGES];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < MSTAGES; i++) begin
        m_q[i]  <= '0;
        c_d[i]  <= '0;
        op_d[i] <= '0;
      end
    end else begin
      m_q[0]  <= prod;
      c_d[0]  <= c_q;
      op_d[0] <= op_q;
      for (int i = 1; i < MSTAGES; i++) begin
        m_q[i]  <= m_q[i-1];
        c_d[i]  <= c_d[i-1];
        op_d[i] <= op_d[i-1];
      end
    end
  end

  // Accumulator stage: one guard bit above PW exposes signed overflow
  logic signed [PW-1:0] p_q;
  logic signed [EW-1:0] m_ext;
  logic signed [EW-1:0] p_ext;
  logic signed [EW-1:0] c_ext;
  logic signed [EW-1:0] sum;
  logic signed [PW-1:0] res;
  logic                 ovf;
  logic                 acc_valid;

  assign acc_valid = v_sr[MSTAGES];
  assign m_ext     = EW'(m_q[MSTAGES-1]);
  assign p_ext     = EW'(p_q);
  assign c_ext     = EW'(c_d[MSTAGES-1]);

  always_comb begin
    sum = '0;
    case (op_d[MSTAGES-1])
      OP_LOAD: sum = m_ext;
      OP_ACC:  sum = p_ext + m_ext;
      OP_ADDC: sum = c_ext + m_ext;
      OP_SUB:  sum = p_ext - m_ext;
      default: sum = m_ext;
    endcase
  end

  assign ovf = sum[PW] ^ sum[PW-1];

  always_comb begin
    res = sum[PW-1:0];
    if (ovf && (SATURATE != 0)) res = sum[PW] ? SAT_MIN : SAT_MAX;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      p_q       <= '0;
      PATDET    <= 1'b0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= acc_valid;
      if (acc_valid) begin
        p_q    <= res;
        PATDET <= (res == PATTERN);
      end
    end
  end

  // Sticky flag: a new overflow takes priority over a simultaneous clear
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                 OVERFLOW <= 1'b0;
    else if (acc_valid && ovf) OVERFLOW <= 1'b1;
    else if (CLR_OVF)          OVERFLOW <= 1'b0;
  end

  assign P     = p_q;
  assign PCOUT = p_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: a 48-bit saturating instance with PATTERN=100 plus
// 36-bit saturating and wrapping instances driven by the same operand stream.
module tb_dsp_mac_pipe;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RSTN;
  int   cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic        in_valid;
  logic [17:0] a_in;
  logic [17:0] b_in;
  logic [47:0] c_in;
  logic [1:0]  opmode;
  logic        clr_ovf;

  logic [47:0] p0, pc0;
  logic        v0, ovf0, pd0;
  logic [35:0] p1, pc1;
  logic        v1, ovf1, pd1;
  logic [35:0] p2, pc2;
  logic        v2, ovf2, pd2;

  dsp_mac_pipe #(.PATTERN(48'd100)) dut0 (
    .CLK(CLK), .RSTN(RSTN), .IN_VALID(in_valid), .A(a_in), .B(b_in), .C(c_in),
    .OPMODE(opmode), .CLR_OVF(clr_ovf), .P(p0), .PCOUT(pc0), .OUT_VALID(v0),
    .OVERFLOW(ovf0), .PATDET(pd0)
  );

  dsp_mac_pipe #(.PW(36), .SATURATE(1)) dut1 (
    .CLK(CLK), .RSTN(RSTN), .IN_VALID(in_valid), .A(a_in), .B(b_in), .C(c_in[35:0]),
    .OPMODE(opmode), .CLR_OVF(clr_ovf), .P(p1), .PCOUT(pc1), .OUT_VALID(v1),
    .OVERFLOW(ovf1), .PATDET(pd1)
  );

  dsp_mac_pipe #(.PW(36), .SATURATE(0)) dut2 (
    .CLK(CLK), .RSTN(RSTN), .IN_VALID(in_valid), .A(a_in), .B(b_in), .C(c_in[35:0]),
    .OPMODE(opmode), .CLR_OVF(clr_ovf), .P(p2), .PCOUT(pc2), .OUT_VALID(v2),
    .OVERFLOW(ovf2), .PATDET(pd2)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [47:0] p48;
    logic [35:0] p36s;
    logic [35:0] p36w;
    logic        pd;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input int a, input int b, input longint c, input logic [1:0] op,
                       input longint e48, input longint e36s, input longint e36w,
                       input logic pd, input bit push);
    exp_t        e;
    logic [31:0] at, bt;
    logic [63:0] ct, x48, xs, xw;
    @(negedge CLK);
    at = a; bt = b; ct = c;
    in_valid = 1'b1;
    a_in     = at[17:0];
    b_in     = bt[17:0];
    c_in     = ct[47:0];
    opmode   = op;
    if (push) begin
      x48 = e48; xs = e36s; xw = e36w;
      e.p48  = x48[47:0];
      e.p36s = xs[35:0];
      e.p36w = xw[35:0];
      e.pd   = pd;
      e.cyc  = cyc + 4;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge CLK);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge CLK);
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (RSTN === 1'b1 && v0 === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("latency_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("p48", 64'(p0), 64'(mon_e.p48));
        check("pcout48", 64'(pc0), 64'(mon_e.p48));
        check("patdet48", 64'(pd0), 64'(mon_e.pd));
        check("valid36s", 64'(v1), 64'd1);
        check("valid36w", 64'(v2), 64'd1);
        check("p36_sat", 64'(p1), 64'(mon_e.p36s));
        check("pcout36_sat", 64'(pc1), 64'(mon_e.p36s));
        check("p36_wrap", 64'(p2), 64'(mon_e.p36w));
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    RSTN = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; c_in = '0;
    opmode = 2'b00; clr_ovf = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_p", 64'(p0), 64'd0);
    check("reset_pcout", 64'(pc0), 64'd0);
    check("reset_out_valid", 64'(v0), 64'd0);
    check("reset_overflow", 64'(ovf0), 64'd0);
    check("reset_patdet", 64'(pd0), 64'd0);
    RSTN = 1'b1;
    idle(2);

    // load latency: 3 * -5
    issue(3, -5, 0, 2'b00, -15, -15, -15, 1'b0, 1);
    idle(1);
    drain();

    // back-to-back accumulate, then subtract
    issue(2, 3, 0, 2'b00, 6, 6, 6, 1'b0, 1);
    issue(4, 5, 0, 2'b01, 26, 26, 26, 1'b0, 1);
    issue(1, -7, 0, 2'b01, 19, 19, 19, 1'b0, 1);
    issue(2, 4, 0, 2'b11, 11, 11, 11, 1'b0, 1);
    idle(1);
    drain();

    // add C with a bubble between; both land on PATTERN
    issue(6, 10, 40, 2'b10, 100, 100, 100, 1'b1, 1);
    idle(1);
    issue(6, 10, 40, 2'b10, 100, 100, 100, 1'b1, 1);
    idle(1);
    drain();
    check("hold_p", 64'(p0), 64'd100);
    check("hold_patdet", 64'(pd0), 64'd1);

    issue(-3, 7, -1000, 2'b10, -1021, -1021, -1021, 1'b0, 1);
    idle(1);
    drain();

    // overflow: 2^34 + 2^34 overflows 36 bits but not 48
    issue(-131072, -131072, 0, 2'b00, 64'sd17179869184, 64'sd17179869184, 64'sd17179869184, 1'b0, 1);
    issue(-131072, -131072, 0, 2'b01, 64'sd34359738368, 64'sd34359738367, -64'sd34359738368, 1'b0, 1);
    idle(1);
    drain();
    check("ovf48_clear", 64'(ovf0), 64'd0);
    check("ovf36_sat_set", 64'(ovf1), 64'd1);
    check("ovf36_wrap_set", 64'(ovf2), 64'd1);

    // clear coincides with a new overflow on the saturating instance only
    issue(-131072, -131072, 0, 2'b01, 64'sd51539607552, 64'sd34359738367, -64'sd17179869184, 1'b0, 1);
    idle(2);
    @(negedge CLK);
    clr_ovf = 1'b1;
    @(negedge CLK);
    clr_ovf = 1'b0;
    check("ovf_set_wins", 64'(ovf1), 64'd1);
    check("ovf_clear_no_set", 64'(ovf2), 64'd0);
    drain();
    @(negedge CLK);
    clr_ovf = 1'b1;
    @(negedge CLK);
    clr_ovf = 1'b0;
    check("ovf_clear_alone", 64'(ovf1), 64'd0);

    // re-arm overflow so the reset has a set flag to clear
    issue(-131072, -131072, 0, 2'b01, 64'sd68719476736, 64'sd34359738367, 0, 1'b0, 1);
    idle(1);
    drain();
    check("ovf_rearmed", 64'(ovf1), 64'd1);

    // reset two cycles after an IN_VALID: operation discarded
    issue(5, 5, 0, 2'b00, 25, 25, 25, 1'b0, 0);
    idle(1);
    @(negedge CLK);
    RSTN = 1'b0;
    #1;
    check("async_reset_p", 64'(p0), 64'd0);
    check("async_reset_pcout", 64'(pc0), 64'd0);
    check("async_reset_p36", 64'(p1), 64'd0);
    check("async_reset_ovf", 64'(ovf1), 64'd0);
    check("async_reset_valid", 64'(v0), 64'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    idle(6);

    // first op after release accumulates from a cleared P
    issue(3, -5, 0, 2'b01, -15, -15, -15, 1'b0, 1);
    idle(1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
